// File: rtl/level_pkg.sv
// Shared types for level_ctrl: FSM states and the saved {level, pc} frame.
// The frame layout follows NUM_LEVELS / PC_WIDTH; keep level_ctrl parameters in step with them.
package level_pkg;
  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned LEVEL_W    = $clog2(NUM_LEVELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    RETURN = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEVEL_W-1:0]  level;
    logic [PC_WIDTH-1:0] pc;
  } frame_t;
endpackage

// File: rtl/lifo_stack.sv
// Frame LIFO holding preempted {level, pc}. Reset clears only the pointer;
// storage contents are left as-is since an empty stack never exposes them.
module lifo_stack import level_pkg::*; #(
  parameter  int unsigned Depth    = NUM_LEVELS - 1,
  localparam int unsigned PtrWidth = $clog2(NUM_LEVELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  frame_t              din,
  output frame_t              top,
  output logic [PtrWidth-1:0] depth,
  output logic                full,
  output logic                empty
);

  frame_t              mem_q [NUM_LEVELS];
  logic [PtrWidth-1:0] ptr_q, ptr_d;

  assign full  = (ptr_q == PtrWidth'(Depth));
  assign empty = (ptr_q == '0);
  assign depth = ptr_q;
  assign top   = mem_q[ptr_q - PtrWidth'(1)];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PtrWidth'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PtrWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/level_ctrl.sv
// Interrupt priority-level controller: drives the register-file bank level, saves/restores
// frames on a LIFO and issues a PC redirect with a one-cycle stall. Option: TAIL_CHAIN_EN.
module level_ctrl import level_pkg::*; #(
  parameter  int unsigned NumLevels  = NUM_LEVELS,
  parameter  int unsigned PcWidth    = PC_WIDTH,
  localparam int unsigned LevelWidth = $clog2(NumLevels),
  localparam int unsigned DepthWidth = $clog2(NumLevels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  irq_valid,
  input  logic [LevelWidth-1:0] irq_prio,
  input  logic [PcWidth-1:0]    irq_vector,
  output logic                  irq_ready,
  input  logic                  ret_en,
  input  logic [PcWidth-1:0]    pc_in,
  output logic [LevelWidth-1:0] level,
  output logic                  pc_load,
  output logic [PcWidth-1:0]    pc_out,
  output logic                  stall,
  output logic [DepthWidth-1:0] depth,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic [PcWidth-1:0]    pc_out_q, pc_out_d;
  logic                  pc_load_q, pc_load_d;
  logic                  err_q, err_d;

  frame_t                top_frame, push_frame;
  logic [DepthWidth-1:0] depth_w;
  logic                  lifo_full, lifo_empty, push, pop;
  logic                  idle, normal_acc, tail_acc;

  lifo_stack #(.Depth(NumLevels - 1)) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_frame),
    .top   (top_frame),
    .depth (depth_w),
    .full  (lifo_full),
    .empty (lifo_empty)
  );

  assign idle       = (state_q == IDLE);
  assign normal_acc = idle && irq_valid && (irq_prio > level_q)
                      && (depth_w < DepthWidth'(NumLevels - 1));
`ifdef TAIL_CHAIN_EN
  // Tail-chain compares against the level the return would restore, not the current one.
  assign tail_acc   = idle && irq_valid && ret_en && !lifo_empty
                      && (irq_prio > top_frame.level);
`else
  assign tail_acc   = 1'b0;
`endif
  assign irq_ready  = tail_acc || (normal_acc && !ret_en);

  assign push_frame.level = level_q;
  assign push_frame.pc    = pc_in;

  always_comb begin
    state_d   = IDLE;
    level_d   = level_q;
    pc_out_d  = pc_out_q;
    pc_load_d = 1'b0;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (idle) begin
      if (tail_acc) begin
        level_d   = irq_prio;
        pc_out_d  = irq_vector;
        pc_load_d = 1'b1;
        state_d   = ENTER;
      end else if (ret_en) begin
        if (lifo_empty) begin
          err_d = 1'b1;
        end else begin
          pop       = 1'b1;
          level_d   = top_frame.level;
          pc_out_d  = top_frame.pc;
          pc_load_d = 1'b1;
          state_d   = RETURN;
        end
      end else if (normal_acc) begin
        if (lifo_full) begin
          err_d = 1'b1;
        end else begin
          push      = 1'b1;
          level_d   = irq_prio;
          pc_out_d  = irq_vector;
          pc_load_d = 1'b1;
          state_d   = ENTER;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      pc_out_q  <= '0;
      pc_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      pc_out_q  <= pc_out_d;
      pc_load_q <= pc_load_d;
      err_q     <= err_d;
    end
  end

  assign level   = level_q;
  assign pc_out  = pc_out_q;
  assign pc_load = pc_load_q;
  assign stall   = (state_q != IDLE);
  assign depth   = depth_w;
  assign err     = err_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: a queue-based model predicts each redirect,
// a monitor pops and checks them when pc_load appears.
module tb_level_ctrl;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq_valid = 1'b0;
  logic [2:0]  irq_prio = '0;
  logic [31:0] irq_vector = '0;
  logic        irq_ready;
  logic        ret_en = 1'b0;
  logic [31:0] pc_in = '0;
  logic [2:0]  level;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        stall;
  logic [2:0]  depth;
  logic        err;

  always #5 clk = ~clk;

  level_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_valid  (irq_valid),
    .irq_prio   (irq_prio),
    .irq_vector (irq_vector),
    .irq_ready  (irq_ready),
    .ret_en     (ret_en),
    .pc_in      (pc_in),
    .level      (level),
    .pc_load    (pc_load),
    .pc_out     (pc_out),
    .stall      (stall),
    .depth      (depth),
    .err        (err)
  );

  typedef struct { int lvl; logic [31:0] pc; } frame_m;
  typedef struct { int lvl; logic [31:0] pc; int dep; } redirect_t;

  frame_m    stk[$];
  redirect_t expq[$];
  int        m_level = 0;
  bit        m_err = 0;
  bit        m_busy = 0;
  bit        mon_en = 0;
  int        n_cmp = 0;
  int        n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural rules: strict-priority preemption with a frame stack.
  function automatic bit model_step(bit v, int prio, logic [31:0] vec, bit ret, logic [31:0] pcin);
    bit        normal;
    bit        tail;
    redirect_t r;
    frame_m    f;
    if (m_busy) begin
      m_busy = 0;
      return 0;
    end
    normal = v && (prio > m_level) && (stk.size() < NL - 1);
    tail   = 0;
`ifdef TAIL_CHAIN_EN
    begin
      int restore;
      restore = (stk.size() > 0) ? stk[$].lvl : 0;
      tail = v && ret && (stk.size() > 0) && (prio > restore);
    end
`endif
    if (tail) begin
      m_level = prio;
      r = '{prio, vec, stk.size()};
      expq.push_back(r);
      m_busy = 1;
      return 1;
    end
    if (ret) begin
      if (stk.size() == 0) begin
        m_err = 1;
        return 0;
      end
      f = stk.pop_back();
      m_level = f.lvl;
      r = '{f.lvl, f.pc, stk.size()};
      expq.push_back(r);
      m_busy = 1;
      return 0;
    end
    if (normal) begin
      f = '{m_level, pcin};
      stk.push_back(f);
      m_level = prio;
      r = '{prio, vec, stk.size()};
      expq.push_back(r);
      m_busy = 1;
      return 1;
    end
    return 0;
  endfunction

  task automatic cycle(input bit v, input int prio, input logic [31:0] vec,
                       input bit ret, input logic [31:0] pcin);
    bit er;
    @(negedge clk);
    irq_valid  = v;
    irq_prio   = prio[2:0];
    irq_vector = vec;
    ret_en     = ret;
    pc_in      = pcin;
    #1;
    er = model_step(v, prio, vec, ret, pcin);
    chk("irq_ready", {63'd0, irq_ready}, {63'd0, er});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    irq_valid = 1'b0;
    ret_en = 1'b0;
    stk.delete();
    expq.delete();
    m_level = 0;
    m_err = 0;
    m_busy = 0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Monitor: every cycle check architectural state; on a redirect pop the scoreboard.
  initial begin
    redirect_t r;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("level", {61'd0, level}, m_level);
        chk("depth", {61'd0, depth}, stk.size());
        chk("err", {63'd0, err}, {63'd0, m_err});
        chk("pc_load", {63'd0, pc_load}, {63'd0, m_busy});
        chk("stall", {63'd0, stall}, {63'd0, m_busy});
        if (expq.size() > 0) begin
          r = expq.pop_front();
          chk("redir_level", {61'd0, level}, r.lvl);
          chk("redir_pc_out", {32'd0, pc_out}, {32'd0, r.pc});
          chk("redir_depth", {61'd0, depth}, r.dep);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset(2);
    mon_en = 1;
    chk("reset_pc_out", {32'd0, pc_out}, 64'd0);
    chk("reset_level", {61'd0, level}, 64'd0);

    // Entry then reset while in ENTER
    cycle(1, 3, 32'h100, 0, 32'h40);
    apply_reset(1);
    chk("rst_mid_enter_level", {61'd0, level}, 64'd0);
    chk("rst_mid_enter_pc_out", {32'd0, pc_out}, 64'd0);
    chk("rst_mid_enter_stall", {63'd0, stall}, 64'd0);

    // Single entry, nesting, two returns, empty return
    cycle(1, 3, 32'h100, 0, 32'h40);
    idle_cycles(1);
    cycle(1, 2, 32'h180, 0, 32'h60);
    cycle(1, 5, 32'h200, 0, 32'h80);
    idle_cycles(1);
    cycle(0, 0, 32'h0, 1, 32'h0);
    idle_cycles(1);
    cycle(0, 0, 32'h0, 1, 32'h0);
    idle_cycles(1);
    cycle(0, 0, 32'h0, 1, 32'h0);
    idle_cycles(2);

    // Simultaneous irq and return at level 5, depth 2
    apply_reset(1);
    cycle(1, 3, 32'h100, 0, 32'h40);
    idle_cycles(1);
    cycle(1, 5, 32'h200, 0, 32'h80);
    idle_cycles(1);
    cycle(1, 4, 32'h300, 1, 32'h90);
    for (int i = 0; i < 4; i++) cycle(1, 4, 32'h300, 0, 32'hA0 + i);
    idle_cycles(1);

    // Back-to-back: request held through ENTER
    apply_reset(1);
    cycle(1, 2, 32'h400, 0, 32'h10);
    cycle(1, 4, 32'h500, 0, 32'h14);
    cycle(1, 4, 32'h500, 0, 32'h18);
    idle_cycles(2);

    // Randomized traffic
    apply_reset(1);
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, NL - 1), $urandom,
            ($urandom_range(0, 3) == 0), $urandom);
      if (i % 200 == 199) apply_reset(1);
    end
    idle_cycles(3);
    chk("scoreboard_drained", expq.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/level_ctrl.md
# level_ctrl

Execution-level controller that sits directly upstream of the banked register file and drives its `level` input. Tracks the current interrupt priority level and accepts preempting interrupt requests. On entry it saves the preempted level and return PC on an internal LIFO; on interrupt return it restores them. Each level switch is a clean pipeline redirect: PC load plus a one-cycle stall.

## Interface
Parameters:
- NumLevels, 8, number of priority levels; level 0 is thread mode. Power of two, ≥2.
- PcWidth, 32, PC / vector width.
- LevelWidth (localparam), $clog2(NumLevels).
- DepthWidth (localparam), $clog2(NumLevels).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_valid  in  1  interrupt request pending.
- irq_prio  in  LevelWidth  priority of pending request.
- irq_vector  in  PcWidth  handler entry address.
- irq_ready  out  1  request accepted this cycle (combinational).
- ret_en  in  1  interrupt-return instruction committed this cycle.
- pc_in  in  PcWidth  PC to resume at if preempted this cycle.
- level  out  LevelWidth  current level, feeds register-file bank select.
- pc_load  out  1  one-cycle redirect strobe.
- pc_out  out  PcWidth  redirect target, valid when pc_load=1.
- stall  out  1  pipeline hold.
- depth  out  DepthWidth  number of saved entries.
- err  out  1  sticky: return with empty stack, or push when full.

## Operation
- FSM states: IDLE, ENTER, RETURN.
- Reset (reset=0 at an edge) clears every register, including mid-ENTER/RETURN. Values: state=IDLE, level=0, depth=0, pc_load=0, pc_out=0, stall=0, err=0. LIFO contents are don't-care.
- Acceptance condition: state==IDLE && irq_valid && irq_prio>level && depth<NumLevels-1. irq_ready equals this condition.
- irq_prio==0 never preempts. Equal priority never preempts.
- Entry (accepted, no ret_en):
  - push {level, pc_in}; depth+1.
  - level<=irq_prio; pc_out<=irq_vector; pc_load<=1; state<=ENTER.
- Return (IDLE && ret_en, depth>0, no accepted irq):
  - pop {lvl, pc}; depth-1.
  - level<=lvl; pc_out<=pc; pc_load<=1; state<=RETURN.
- Return with depth==0: err<=1. Nothing else changes; state stays IDLE.
- ENTER and RETURN each last one cycle, then the FSM returns to IDLE. All inputs are ignored in these states; irq_ready=0.
- Full LIFO: cannot occur under strict priority ordering. If the acceptance logic is bypassed, err<=1 and no push occurs.
- Simultaneous accepted irq and ret_en: see Configuration.
- err clears only on reset.

## Timing
- Decision in IDLE cycle t. At t+1: level, pc_out and depth hold the new values; pc_load=1 and stall=1 for exactly that cycle.
- At t+2: state is IDLE and a new decision is possible. Minimum spacing between switches is 2 cycles.
- level never changes outside the t+1 update. The register file therefore sees the new bank from cycle t+1.
- stall is asserted only in ENTER/RETURN.

## Configuration
- Macro: TAIL_CHAIN_EN.
- Defined: an accepted irq coincident with ret_en, whose irq_prio > the level that the return would restore, tail-chains:
  - no pop, no push; depth unchanged.
  - level<=irq_prio; pc_out<=irq_vector; state<=ENTER.
  - If irq_prio ≤ the restore level, a normal return is performed and the irq is re-evaluated in the next IDLE cycle.
- Undefined: ret_en always wins. irq_ready=0 in that cycle and the irq is re-evaluated in the next IDLE cycle.

## Structure
- Package level_pkg holds:
  - state enum (IDLE, ENTER, RETURN).
  - packed struct frame_t {level, pc}, parameterised through package parameters.
- Sub-module lifo_stack: push, pop, top and depth for frame_t. Depth NumLevels-1. Synchronous active-low reset clears only its pointer.
- level_ctrl holds the FSM, the acceptance logic and the output registers.

## Test plan
- Reset check: apply reset=0 mid-ENTER -> next cycle level=0, depth=0, pc_load=0, stall=0, err=0.
- Single entry: level=0, irq prio 3, vector 'h100, pc_in 'h40 -> irq_ready=1. Next cycle: level=3, pc_out='h100, pc_load=1, stall=1, depth=1.
- Nesting: from level 3, irq prio 2 -> irq_ready=0. Then prio 5 -> level=5, depth=2. ret_en -> level=3, pc_out=the saved pc. ret_en again -> level=0, pc_out='h40.
- Empty return: ret_en at depth 0 -> err=1; level, pc_load and depth unchanged.
- Simultaneous irq and return at level 5, depth 2, irq prio 4: with TAIL_CHAIN_EN -> level=4, pc_out=vector, depth=2. Without it -> level=3, then the irq is taken 2 cycles later.
- Back-to-back: irq held valid during ENTER -> irq_ready=0. Next acceptance no earlier than t+2.
